// File: rtl/dm_multicycle.sv
// Multicycle data memory: zero-fills itself after reset, then serves one load/store
// per LATENCY cycles with lane selection, sign/zero extension and fault detection.
module dm_multicycle #(
  parameter int unsigned ADDR_BITS = 12,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned DEPTH  = 1 << ADDR_BITS;
  localparam bit          DIRECT = (LATENCY == 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_e;

  state_e                state_q;
  logic [ADDR_BITS-1:0]  clr_idx_q;
  logic [3:0]            wait_cnt_q;
  logic                  we_q;
  logic [2:0]            op_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic                  resp_valid_q;
  logic [31:0]           resp_rdata_q;
  logic                  resp_err_q;
  logic [31:0]           mem_q [DEPTH];

  logic                  accept_s;
  logic                  commit_s;
  logic                  acc_we_s;
  logic [2:0]            acc_op_s;
  logic [31:0]           acc_addr_s;
  logic [31:0]           acc_wdata_s;
  logic [ADDR_BITS-1:0]  acc_idx_s;
  logic                  fault_s;
  logic                  mem_we_s;
  logic [ADDR_BITS-1:0]  mem_widx_s;
  logic [31:0]           mem_wdata_s;

  function automatic logic [31:0] merge_store(input logic [31:0] old_word,
                                              input logic [31:0] wd,
                                              input logic [2:0]  op,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = old_word;
    case (op)
      3'd0:       r = wd;
      3'd1:       r[{lane[1], 4'b0000} +: 16] = wd[15:0];
      3'd2:       r[{lane, 3'b000} +: 8] = wd[7:0];
      default:    r = old_word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  op,
                                               input logic [1:0]  lane);
    logic [15:0] h;
    logic [7:0]  b;
    logic [31:0] r;
    h = word[{lane[1], 4'b0000} +: 16];
    b = word[{lane, 3'b000} +: 8];
    case (op)
      3'd0:    r = word;
      3'd1:    r = {{16{h[15]}}, h};
      3'd2:    r = {{24{b[7]}}, b};
      3'd3:    r = {16'h0000, h};
      3'd4:    r = {24'h000000, b};
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  assign req_ready = (state_q == S_IDLE) || (state_q == S_RESP);
  assign accept_s  = req_valid && req_ready;
  assign busy      = (state_q != S_IDLE) && !((state_q == S_RESP) && !accept_s);

  // With single-cycle latency the commit edge is the accept edge, so the live request is used.
  assign acc_we_s    = DIRECT ? req_we    : we_q;
  assign acc_op_s    = DIRECT ? req_op    : op_q;
  assign acc_addr_s  = DIRECT ? req_addr  : addr_q;
  assign acc_wdata_s = DIRECT ? req_wdata : wdata_q;
  assign acc_idx_s   = acc_addr_s[ADDR_BITS+1:2];

  assign commit_s = DIRECT ? accept_s
                           : ((state_q == S_WAIT) && (wait_cnt_q == 4'd1));

  always_comb begin
    fault_s = 1'b0;
    if ((acc_op_s == 3'd0) && (acc_addr_s[1:0] != 2'b00)) fault_s = 1'b1;
    if (((acc_op_s == 3'd1) || (acc_op_s == 3'd3)) && acc_addr_s[0]) fault_s = 1'b1;
    if (acc_addr_s[31:ADDR_BITS+2] != BASE_ADDR[31:ADDR_BITS+2]) fault_s = 1'b1;
    if (acc_op_s > 3'd4) fault_s = 1'b1;
    if (acc_we_s && ((acc_op_s == 3'd3) || (acc_op_s == 3'd4))) fault_s = 1'b1;
  end

  always_comb begin
    mem_we_s    = 1'b0;
    mem_widx_s  = acc_idx_s;
    mem_wdata_s = merge_store(mem_q[acc_idx_s], acc_wdata_s, acc_op_s, acc_addr_s[1:0]);
    if (state_q == S_CLEAR) begin
      mem_we_s    = 1'b1;
      mem_widx_s  = clr_idx_q;
      mem_wdata_s = 32'h0000_0000;
    end else if (commit_s && acc_we_s && !fault_s) begin
      mem_we_s    = 1'b1;
    end else begin
      mem_we_s    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[mem_widx_s] <= mem_wdata_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      clr_idx_q    <= '0;
      wait_cnt_q   <= 4'd0;
      we_q         <= 1'b0;
      op_q         <= 3'd0;
      addr_q       <= 32'h0000_0000;
      wdata_q      <= 32'h0000_0000;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      resp_err_q   <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      if (accept_s) begin
        we_q    <= req_we;
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      case (state_q)
        S_CLEAR: begin
          clr_idx_q <= clr_idx_q + {{(ADDR_BITS-1){1'b0}}, 1'b1};
          if (clr_idx_q == {ADDR_BITS{1'b1}}) state_q <= S_IDLE;
        end
        S_IDLE, S_RESP: begin
          if (accept_s) begin
            wait_cnt_q <= 4'(LATENCY - 1);
            state_q    <= DIRECT ? S_RESP : S_WAIT;
          end else begin
            state_q    <= S_IDLE;
          end
        end
        S_WAIT: begin
          if (wait_cnt_q == 4'd1) state_q <= S_RESP;
          else wait_cnt_q <= wait_cnt_q - 4'd1;
        end
        default: state_q <= S_CLEAR;
      endcase
      if (commit_s) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= fault_s;
        resp_rdata_q <= (fault_s || acc_we_s) ? 32'h0000_0000
                        : load_extract(mem_q[acc_idx_s], acc_op_s, acc_addr_s[1:0]);
      end
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_multicycle.sv
// Scoreboard bench for dm_multicycle (ADDR_BITS=4, LATENCY=2): stimulus pushes expected
// responses with their due cycle, a negedge monitor pops and compares on resp_valid.
module tb_dm_multicycle;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        busy;

  dm_multicycle #(.ADDR_BITS(4), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (resp_valid) begin
      vectors++;
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp: got resp_valid at cycle %0d (rdata %h), required none", cyc, resp_rdata);
      end else begin
        mon_e = sb_q.pop_front();
        if (resp_rdata !== mon_e.rdata || resp_err !== mon_e.err || cyc != mon_e.cyc) begin
          miscompares++;
          $display("FAIL resp: got rdata %h err %b cycle %0d, required rdata %h err %b cycle %0d",
                   resp_rdata, resp_err, cyc, mon_e.rdata, mon_e.err, mon_e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                       input bit expect_resp);
    int   n;
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: req_ready still %b after %0d cycles, required 1", req_ready, n);
      req_valid = 1'b0;
    end else begin
      if (expect_resp) begin
        e.rdata = exp_rd;
        e.err   = exp_err;
        e.cyc   = cyc + 2;
        sb_q.push_back(e);
      end
      @(posedge clk);
    end
  endtask

  // Drops the request and scrambles the other inputs so a latched access must not depend on them.
  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0;
    req_we    = 1'b1;
    req_op    = 3'd7;
    req_addr  = 32'hFFFF_FFFC;
    req_wdata = 32'hA5A5_A5A5;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb_q.size());
      sb_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check("clear_ready", {31'd0, req_ready}, 32'd0);
      check("clear_busy", {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    check("post_clear_ready", {31'd0, req_ready}, 32'd1);
    check("post_clear_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 16; i++) issue(1'b0, 3'd0, 32'(i * 4), 32'h0, 32'h0, 1'b0, 1'b1);
    idle();
    drain();

    issue(1'b1, 3'd0, 32'h8, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    idle();
    issue(1'b0, 3'd4, 32'h9, 32'h0, 32'h0000_00BE, 1'b0, 1'b1);
    idle();
    issue(1'b0, 3'd2, 32'hB, 32'h0, 32'hFFFF_FFDE, 1'b0, 1'b1);
    idle();
    drain();

    issue(1'b1, 3'd1, 32'h6, 32'h0000_8001, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 3'd1, 32'h6, 32'h0, 32'hFFFF_8001, 1'b0, 1'b1);
    issue(1'b0, 3'd3, 32'h6, 32'h0, 32'h0000_8001, 1'b0, 1'b1);
    issue(1'b0, 3'd0, 32'h4, 32'h0, 32'h8001_0000, 1'b0, 1'b1);
    issue(1'b1, 3'd2, 32'h1, 32'hFFFF_FF55, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 3'd4, 32'h1, 32'h0, 32'h0000_0055, 1'b0, 1'b1);
    issue(1'b0, 3'd3, 32'h0, 32'h0, 32'h0000_5500, 1'b0, 1'b1);
    idle();
    drain();

    issue(1'b0, 3'd0, 32'h2, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 3'd1, 32'h3, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 3'd0, 32'h40, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 3'd5, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 3'd4, 32'h0, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    issue(1'b1, 3'd0, 32'h40, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1);
    issue(1'b0, 3'd0, 32'h0, 32'h0, 32'h0000_5500, 1'b0, 1'b1);
    idle();
    drain();
    check("idle_busy", {31'd0, busy}, 32'd0);

    issue(1'b0, 3'd0, 32'h8, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1);
    issue(1'b0, 3'd0, 32'h4, 32'h0, 32'h8001_0000, 1'b0, 1'b1);
    issue(1'b0, 3'd0, 32'h0, 32'h0, 32'h0000_5500, 1'b0, 1'b1);
    issue(1'b0, 3'd4, 32'h9, 32'h0, 32'h0000_00BE, 1'b0, 1'b1);
    idle();
    drain();

    issue(1'b1, 3'd0, 32'h0, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd1);
    check("abort_ready", {31'd0, req_ready}, 32'd0);
    check("abort_rdata", resp_rdata, 32'h0);
    check("abort_err", {31'd0, resp_err}, 32'd0);
    @(negedge clk);
    check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    reset = 1'b0;
    issue(1'b0, 3'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    issue(1'b0, 3'd0, 32'h8, 32'h0, 32'h0, 1'b0, 1'b1);
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
